cosim_reg_write_serializer: RTL and testbench
=============================================

# cosim_reg_write_serializer

SV-to-C++ end of the cosim register-write log channel. Accepts register-write commit records from the DUT-side commit tracker, buffers them in a small FIFO and emits each one as LOG_REG_WRITE_ITEM_DPI_WORDS (6) DPI_W-bit words. It is the mirror of the C++-to-SV packing: the DPI export task pops words one at a time and hands them to Spike for comparison.

## Interface
- DEPTH, 4: item FIFO depth; power of two, at least 2.
- clk_i  in  1  clock; all state on rising edge.
- rst_ni  in  1  asynchronous, active-low reset.
- flush_i  in  1  synchronous clear of the FIFO and of any item being serialized.
- item_valid_i  in  1  record valid.
- item_ready_o  out  1  record accepted when valid and ready are both high.
- item_type_i  in  REG_KEY_TYPE_W (4)  register class (x/f/v/csr).
- item_id_i  in  REG_KEY_ID_W (60)  register identifier.
- item_value_i  in  FREG_W (128)  written value; x-register writes zero-extend from XREG_W.
- word_valid_o  out  1  word available.
- word_ready_i  in  1  consumer takes the word.
- word_data_o  out  DPI_W (32)  current word.
- word_idx_o  out  3  index 0..5 of the current word within its item.
- word_last_o  out  1  high on word 5.
- item_cnt_o  out  32  completed items; see Configuration.

## Operation
- The key is {item_type_i, item_id_i}: 64 bits, with the type in bits 63:60.
- Word order is little-endian:
  - word 0 = key[31:0]; word 1 = key[63:32].
  - words 2..5 = value[31:0], value[63:32], value[95:64], value[127:96].
- FIFO:
  - item_ready_o = !full (combinational from FIFO state). There is no push-through when full, even if a pop occurs in the same cycle.
  - The push stores the whole record.
- Serializer FSM with two states:
  - IDLE: word_valid_o = 0. If the FIFO is non-empty, pop into the holding register, set idx = 0 and go to SEND.
  - SEND: word_valid_o = 1. On handshake with idx < 5, idx increments. On handshake with idx = 5:
    - FIFO non-empty: pop the next item, set idx = 0 and stay in SEND.
    - FIFO empty: go to IDLE.
- Output stability: while word_valid_o && !word_ready_i, word_data_o, word_idx_o and word_last_o stay stable.
- Simultaneous push into an empty FIFO and a serializer load: the load sees the FIFO as empty; the item is loaded on the next edge.
- flush_i:
  - Empties the FIFO, returns the FSM to IDLE and sets word_valid_o = 0 on the next cycle.
  - Any push in the same cycle is dropped.
  - item_cnt_o is not cleared.
- Reset mid-item aborts the item; no partial item resumes.

## Timing
- Reset values:
  - item_ready_o = 1 (FIFO empty).
  - word_valid_o = 0, word_data_o = 0, word_idx_o = 0, word_last_o = 0, item_cnt_o = 0.
- Latency: a record accepted at edge t has word 0 valid from edge t+2 (push at t, load at t+1).
- Throughput: one word per cycle with word_ready_i held high. Back-to-back items have no bubble between word 5 and the next word 0.
- Full: with DEPTH items stored plus one in SEND, item_ready_o stays 0 until the cycle after the next load.

## Configuration
- COSIM_SER_ITEM_CNT_EN:
  - Defined: item_cnt_o increments on every word_last_o handshake and wraps from 2^32-1 to 0.
  - Undefined: the counter is not built and item_cnt_o is tied to 0.
  - The port exists in both builds.

## Structure
- cosim_constants_pkg holds the shared constants and types:
  - Constants: XREG_W, FREG_W, DPI_W, REG_KEY_TYPE_W, REG_KEY_ID_W, LOG_REG_WRITE_ITEM_DPI_WORDS.
  - New typedef: reg_write_item_t = packed struct {type, id, value} (192 bits).
- One sub-module: cosim_item_fifo, a parameterised (item type, DEPTH) synchronous FIFO with full/empty, push/pop and flush.
- The serializer FSM and word mux live in the top.

## Test plan
- Single item: type=1, id=5, value=0x...DEADBEEF_CAFEF00D, ready held high -> words 0x00000005, 0x10000000, 0xCAFEF00D, 0xDEADBEEF, 0, 0. word_last_o only on idx 5; word 0 arrives 2 cycles after accept.
- Backpressure: word_ready_i low for 3 cycles at idx 2 -> data/idx stable for those 3 cycles, then the sequence resumes with no word lost.
- Fill: push 6 items with ready low -> item_ready_o drops after DEPTH+1 accepts (5). After ready is raised, 30 words arrive in order with no gap.
- Back-to-back: two items, ready high -> word 5 of item A is followed directly by word 0 of item B in the next cycle.
- Flush mid-item at idx 3 with 2 items queued -> word_valid_o = 0 the next cycle and item_ready_o = 1. A new item afterward serializes from idx 0.
- Async reset pulse mid-item -> all outputs go to reset values immediately. With COSIM_SER_ITEM_CNT_EN, item_cnt_o counts 3 after three full items and stays 0 when the macro is undefined.

Source files
------------

// File: rtl/cosim_constants_pkg.sv
// Shared cosim constants and the register-write log record type.
// Used by cosim_item_fifo and cosim_reg_write_serializer.
package cosim_constants_pkg;

  localparam int unsigned XREG_W                       = 64;
  localparam int unsigned FREG_W                       = 128;
  localparam int unsigned DPI_W                        = 32;
  localparam int unsigned REG_KEY_TYPE_W               = 4;
  localparam int unsigned REG_KEY_ID_W                 = 60;
  localparam int unsigned LOG_REG_WRITE_ITEM_DPI_WORDS = 6;

  localparam int unsigned REG_KEY_W = REG_KEY_TYPE_W + REG_KEY_ID_W;

  // Index of the final word of an item on the DPI side.
  localparam logic [2:0] LAST_WORD_IDX = 3'(LOG_REG_WRITE_ITEM_DPI_WORDS - 1);

  // One commit record: key = {reg_type, id}, followed by the written value.
  typedef struct packed {
    logic [REG_KEY_TYPE_W-1:0] reg_type;
    logic [REG_KEY_ID_W-1:0]   id;
    logic [FREG_W-1:0]         value;
  } reg_write_item_t;

  // Little-endian word select: key low/high words first, then value words.
  function automatic logic [DPI_W-1:0] item_word(input reg_write_item_t item,
                                                 input logic [2:0]      idx);
    logic [REG_KEY_W-1:0] key;
    key = {item.reg_type, item.id};
    case (idx)
      3'd0:    item_word = key[31:0];
      3'd1:    item_word = key[63:32];
      3'd2:    item_word = item.value[31:0];
      3'd3:    item_word = item.value[63:32];
      3'd4:    item_word = item.value[95:64];
      3'd5:    item_word = item.value[127:96];
      default: item_word = 32'h0000_0000;
    endcase
  endfunction

endpackage

// File: rtl/cosim_item_fifo.sv
// Small synchronous FIFO for whole records, with full/empty and a
// synchronous flush that empties it. No push-through when full.
module cosim_item_fifo #(
  parameter type         item_t = logic,
  parameter int unsigned DEPTH  = 4
) (
  input  logic  clk_i,
  input  logic  rst_ni,
  input  logic  flush_i,
  input  logic  push_i,
  input  item_t data_i,
  input  logic  pop_i,
  output item_t data_o,
  output logic  full_o,
  output logic  empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  // Pointers carry one extra wrap bit to tell full from empty.
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  item_t       mem_q [DEPTH];
  logic        push_en_s;
  logic        pop_en_s;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign data_o  = mem_q[rd_ptr_q[AW-1:0]];

  // Qualify push/pop against occupancy; flush drops both.
  always_comb begin
    push_en_s = push_i && !full_o && !flush_i;
    pop_en_s  = pop_i && !empty_o && !flush_i;
  end

  // Next pointer values: flush realigns read onto write.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush_i) begin
      rd_ptr_d = wr_ptr_q;
    end else begin
      if (push_en_s) begin
        wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, 1'b1};
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_en_s) begin
        rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, 1'b1};
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
    end
  end

  // Pointer registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Record storage; contents are only meaningful between the pointers.
  always_ff @(posedge clk_i) begin
    if (push_en_s) begin
      mem_q[wr_ptr_q[AW-1:0]] <= data_i;
    end
  end

endmodule

// File: rtl/cosim_reg_write_serializer.sv
// Register-write log serializer: buffers commit records and emits each as
// six little-endian DPI words (key low, key high, value[31:0]..value[127:96]).
// Optional build macro COSIM_SER_ITEM_CNT_EN enables the completed-item
// counter on item_cnt_o; without it item_cnt_o is tied to zero.
module cosim_reg_write_serializer
  import cosim_constants_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      flush_i,
  input  logic                      item_valid_i,
  output logic                      item_ready_o,
  input  logic [REG_KEY_TYPE_W-1:0] item_type_i,
  input  logic [REG_KEY_ID_W-1:0]   item_id_i,
  input  logic [FREG_W-1:0]         item_value_i,
  output logic                      word_valid_o,
  input  logic                      word_ready_i,
  output logic [DPI_W-1:0]          word_data_o,
  output logic [2:0]                word_idx_o,
  output logic                      word_last_o,
  output logic [31:0]               item_cnt_o
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_SEND = 1'b1;

  logic [0:0]      state_q, state_d;
  logic [2:0]      idx_q, idx_d;
  reg_write_item_t hold_q, hold_d;

  reg_write_item_t push_item_s;
  reg_write_item_t fifo_data_s;
  logic            fifo_full_s;
  logic            fifo_empty_s;
  logic            fifo_pop_s;
  logic            word_hs_s;

  assign push_item_s  = '{reg_type: item_type_i, id: item_id_i, value: item_value_i};
  assign item_ready_o = !fifo_full_s;

  cosim_item_fifo #(
    .item_t (reg_write_item_t),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .flush_i (flush_i),
    .push_i  (item_valid_i),
    .data_i  (push_item_s),
    .pop_i   (fifo_pop_s),
    .data_o  (fifo_data_s),
    .full_o  (fifo_full_s),
    .empty_o (fifo_empty_s)
  );

  // Outputs come straight from the holding register and word index flops.
  assign word_valid_o = (state_q == ST_SEND);
  assign word_idx_o   = idx_q;
  assign word_last_o  = word_valid_o && (idx_q == LAST_WORD_IDX);
  assign word_data_o  = item_word(hold_q, idx_q);
  assign word_hs_s    = word_valid_o && word_ready_i;

  // Serializer FSM: load from FIFO, step through six words, chain the next item.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    hold_d     = hold_q;
    fifo_pop_s = 1'b0;
    if (flush_i) begin
      state_d = ST_IDLE;
      idx_d   = 3'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (!fifo_empty_s) begin
            fifo_pop_s = 1'b1;
            hold_d     = fifo_data_s;
            idx_d      = 3'd0;
            state_d    = ST_SEND;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_SEND: begin
          if (word_ready_i) begin
            if (idx_q != LAST_WORD_IDX) begin
              idx_d = idx_q + 3'd1;
            end else if (!fifo_empty_s) begin
              // Chain directly into the next item: no bubble after word 5.
              fifo_pop_s = 1'b1;
              hold_d     = fifo_data_s;
              idx_d      = 3'd0;
            end else begin
              idx_d   = 3'd0;
              state_d = ST_IDLE;
            end
          end else begin
            idx_d = idx_q;
          end
        end
        default: begin
          state_d = ST_IDLE;
          idx_d   = 3'd0;
        end
      endcase
    end
  end

  // FSM, word index and holding register flops.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      idx_q   <= 3'd0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      hold_q  <= hold_d;
    end
  end

`ifdef COSIM_SER_ITEM_CNT_EN
  logic [31:0] item_cnt_q, item_cnt_d;

  // Count each completed item; flush does not clear it, wraps naturally.
  always_comb begin
    if (word_hs_s && word_last_o) begin
      item_cnt_d = item_cnt_q + 32'd1;
    end else begin
      item_cnt_d = item_cnt_q;
    end
  end

  // Completed-item counter flop.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      item_cnt_q <= 32'd0;
    end else begin
      item_cnt_q <= item_cnt_d;
    end
  end

  assign item_cnt_o = item_cnt_q;
`else
  logic unused_hs_s;
  assign unused_hs_s = word_hs_s;
  assign item_cnt_o  = 32'd0;
`endif

endmodule

// File: tb/tb_cosim_reg_write_serializer.sv
// Scoreboard bench for cosim_reg_write_serializer: the driver pushes the six
// expected words of every accepted record into a queue; an independent
// monitor pops and compares on every word handshake.
module tb_cosim_reg_write_serializer;

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic          flush_i;
  logic          item_valid_i;
  logic          item_ready_o;
  logic [3:0]    item_type_i;
  logic [59:0]   item_id_i;
  logic [127:0]  item_value_i;
  logic          word_valid_o;
  logic          word_ready_i;
  logic [31:0]   word_data_o;
  logic [2:0]    word_idx_o;
  logic          word_last_o;
  logic [31:0]   item_cnt_o;

  cosim_reg_write_serializer #(.DEPTH(4)) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .flush_i      (flush_i),
    .item_valid_i (item_valid_i),
    .item_ready_o (item_ready_o),
    .item_type_i  (item_type_i),
    .item_id_i    (item_id_i),
    .item_value_i (item_value_i),
    .word_valid_o (word_valid_o),
    .word_ready_i (word_ready_i),
    .word_data_o  (word_data_o),
    .word_idx_o   (word_idx_o),
    .word_last_o  (word_last_o),
    .item_cnt_o   (item_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  int n_chk  = 0;
  int n_pass = 0;
  logic [35:0] exp_q[$];      // {last, idx[2:0], data[31:0]}
  int unsigned ecnt = 0;      // completed items observed since reset
  bit rand_rdy = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [31:0] exp_cnt();
`ifdef COSIM_SER_ITEM_CNT_EN
    return ecnt;
`else
    return 32'd0;
`endif
  endfunction

  // Reference model: the record is {value, key} read as 32-bit words, LSW first.
  task automatic model_push(input logic [3:0] t, input logic [59:0] id, input logic [127:0] v);
    logic [191:0] rec;
    logic [191:0] sh;
    rec = {v, t, id};
    for (int k = 0; k < 6; k++) begin
      sh = rec >> (32 * k);
      exp_q.push_back({(k == 5), 3'(k), sh[31:0]});
    end
  endtask

  // Monitor: compare every handshake against the scoreboard; check stalls hold.
  logic        prev_stall = 1'b0, prev_flush = 1'b0, prev_rst = 1'b0;
  logic [31:0] prev_data;
  logic [2:0]  prev_idx;
  always @(negedge clk_i) begin
    logic [35:0] e;
    if (rst_ni) begin
      if (prev_stall && prev_rst && !prev_flush) begin
        chk("stall_valid", word_valid_o, 1'b1);
        chk("stall_data", word_data_o, prev_data);
        chk("stall_idx", word_idx_o, prev_idx);
      end
      if (word_valid_o && word_ready_i) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_word", word_data_o, 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          chk("word_data", word_data_o, e[31:0]);
          chk("word_idx", word_idx_o, e[34:32]);
          chk("word_last", word_last_o, e[35]);
          if (e[35]) ecnt++;
        end
      end
    end
    prev_stall = rst_ni && word_valid_o && !word_ready_i;
    prev_data  = word_data_o;
    prev_idx   = word_idx_o;
    prev_flush = flush_i;
    prev_rst   = rst_ni;
  end

  // Random consumer backpressure while enabled.
  always @(posedge clk_i) begin
    if (rand_rdy) begin
      #1 word_ready_i = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic push_item(input logic [3:0] t, input logic [59:0] id, input logic [127:0] v);
    bit acc;
    int n;
    acc = 1'b0;
    n = 0;
    item_valid_i = 1'b1;
    item_type_i  = t;
    item_id_i    = id;
    item_value_i = v;
    while (!acc && n < 200) begin
      @(negedge clk_i);
      acc = item_ready_o;
      tick();
      n++;
    end
    item_valid_i = 1'b0;
    if (acc) model_push(t, id, v);
    else chk("push_timeout", 1'b0, 1'b1);
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (!(exp_q.size() == 0 && !word_valid_o) && n < budget) begin
      tick();
      n++;
    end
    chk("drain_done", (exp_q.size() == 0 && !word_valid_o), 1'b1);
  endtask

  task automatic wait_idx(input logic [2:0] want);
    int n;
    n = 0;
    while (!(word_valid_o && word_idx_o == want) && n < 100) begin
      tick();
      n++;
    end
    chk("wait_idx", (word_valid_o && word_idx_o == want), 1'b1);
  endtask

  task automatic rand_item();
    logic [127:0] v;
    logic [3:0]   t;
    t = 4'($urandom_range(0, 3));
    v = {$urandom, $urandom, $urandom, $urandom};
    if (t == 4'd0) v[127:64] = 64'd0;   // x-register writes are zero-extended
    push_item(t, {28'($urandom), $urandom}, v);
  endtask

  initial begin
    int nacc;
    logic [31:0] d;
    bit seen;
    rst_ni = 1'b0; flush_i = 1'b0; item_valid_i = 1'b0; word_ready_i = 1'b1;
    item_type_i = 4'd0; item_id_i = 60'd0; item_value_i = 128'd0;

    // Reset values
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    chk("rst_item_ready", item_ready_o, 1'b1);
    chk("rst_word_valid", word_valid_o, 1'b0);
    chk("rst_word_data", word_data_o, 32'd0);
    chk("rst_word_idx", word_idx_o, 3'd0);
    chk("rst_word_last", word_last_o, 1'b0);
    chk("rst_item_cnt", item_cnt_o, 32'd0);
    @(posedge clk_i); #1 rst_ni = 1'b1;
    tick();

    // Single item with latency check
    push_item(4'd1, 60'd5, 128'hDEAD_BEEF_CAFE_F00D);
    chk("lat_not_yet", word_valid_o, 1'b0);
    tick();
    chk("lat_valid", word_valid_o, 1'b1);
    chk("lat_word0", word_data_o, 32'h0000_0005);
    drain(50);
    chk("cnt_one", item_cnt_o, exp_cnt());

    // Backpressure at idx 2 for three cycles
    push_item(4'd2, 60'h123_4567_89AB_CDEF, {$urandom, $urandom, $urandom, $urandom});
    wait_idx(3'd2);
    word_ready_i = 1'b0;
    d = word_data_o;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp_data", word_data_o, d);
      chk("bp_idx", word_idx_o, 3'd2);
    end
    word_ready_i = 1'b1;
    drain(50);

    // Fill with consumer stalled: five accepts, then back-pressure
    word_ready_i = 1'b0;
    nacc = 0;
    for (int k = 0; k < 6; k++) begin
      item_valid_i = 1'b1;
      item_type_i  = 4'(k);
      item_id_i    = 60'(k * 17 + 3);
      item_value_i = {$urandom, $urandom, $urandom, $urandom};
      @(negedge clk_i);
      if (item_ready_o) begin
        model_push(item_type_i, item_id_i, item_value_i);
        nacc++;
      end
      tick();
    end
    item_valid_i = 1'b0;
    chk("fill_accepts", nacc, 5);
    chk("fill_not_ready", item_ready_o, 1'b0);
    tick(); tick();
    chk("fill_hold_not_ready", item_ready_o, 1'b0);
    word_ready_i = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk_i);
      chk("fill_no_gap", word_valid_o, 1'b1);
    end
    tick();
    drain(20);

    // Back-to-back: word 5 of A followed by word 0 of B
    word_ready_i = 1'b0;
    rand_item();
    rand_item();
    word_ready_i = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk_i);
      if (word_valid_o && word_last_o) seen = 1'b1;
    end
    chk("b2b_saw_last", seen, 1'b1);
    @(negedge clk_i);
    chk("b2b_valid", word_valid_o, 1'b1);
    chk("b2b_idx0", word_idx_o, 3'd0);
    tick();
    drain(50);

    // Flush mid-item with two queued
    word_ready_i = 1'b0;
    rand_item(); rand_item(); rand_item();
    word_ready_i = 1'b1;
    wait_idx(3'd3);
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    exp_q.delete();
    chk("flush_valid", word_valid_o, 1'b0);
    chk("flush_ready", item_ready_o, 1'b1);
    tick();
    chk("flush_stays_idle", word_valid_o, 1'b0);
    rand_item();
    drain(50);
    chk("flush_cnt_kept", item_cnt_o, exp_cnt());

    // Reset, three items, count, then async reset mid-item
    rst_ni = 1'b0; exp_q.delete(); ecnt = 0;
    tick(); rst_ni = 1'b1; tick();
    rand_item(); rand_item(); rand_item();
    drain(100);
    chk("cnt_three", item_cnt_o, exp_cnt());
    rand_item();
    wait_idx(3'd2);
    #3 rst_ni = 1'b0;
    exp_q.delete();
    ecnt = 0;
    #1;
    chk("arst_valid", word_valid_o, 1'b0);
    chk("arst_data", word_data_o, 32'd0);
    chk("arst_idx", word_idx_o, 3'd0);
    chk("arst_last", word_last_o, 1'b0);
    chk("arst_cnt", item_cnt_o, 32'd0);
    chk("arst_ready", item_ready_o, 1'b1);
    tick(); tick();
    rst_ni = 1'b1;
    tick();
    chk("arst_no_resume", word_valid_o, 1'b0);
    rand_item();
    drain(50);

    // Randomized traffic with random consumer stalls
    rand_rdy = 1'b1;
    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(0, 2)) tick();
      rand_item();
    end
    rand_rdy = 1'b0;
    tick();
    word_ready_i = 1'b1;
    drain(2000);
    chk("cnt_final", item_cnt_o, exp_cnt());

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
